// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding buffer, so that a steady
// stream of word offers produces a gapless 1 bit/clk stream on x.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             xfer;

    // ready is just the inverse of hold_full, so a transfer never needs din timing
    assign xfer = load & ~hold_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    sh_d    = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    // last bit: refill from holding buffer first, then from din
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        sh_d = din;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (MSB_FIRST)
                        sh_d = {sh_q[WIDTH-2:0], 1'b0};
                    else
                        sh_d = {1'b0, sh_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (xfer) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == SHIFT);
    assign x_valid   = busy;
    assign x         = busy ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
    assign word_done = busy && (cnt_q == LAST);
    assign ready     = ~hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed cycle table for an MSB-first instance plus a short LSB-first /
// IDLE_BIT=1 sequence on a second instance.
module tb_bit_serializer;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // MSB-first, IDLE_BIT=0
    logic       rst, load, ready, x, x_valid, word_done, busy;
    logic [7:0] din;
    // LSB-first, IDLE_BIT=1
    logic       rst1, load1, ready1, x1, x_valid1, word_done1, busy1;
    logic [7:0] din1;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din), .load(load), .ready(ready), .x(x),
        .x_valid(x_valid), .word_done(word_done), .busy(busy));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .din(din1), .load(load1), .ready(ready1), .x(x1),
        .x_valid(x_valid1), .word_done(word_done1), .busy(busy1));

    // one row = inputs held over one edge, then {x,x_valid,word_done,ready,busy} after it
    typedef struct {
        string      nm;
        logic       r;
        logic       l;
        logic [7:0] d;
        logic [4:0] e;
        int         det;   // expected cumulative 1011 detections, -1 = not checked
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [3:0] det_w = 4'd0;
    int   det_cnt = 0;

    task automatic add(input string nm, input logic r, input logic l, input logic [7:0] d,
                       input logic ex, input logic ev, input logic edn, input logic er,
                       input logic eb, input int det = -1);
        vec_t v;
        v.nm = nm; v.r = r; v.l = l; v.d = d; v.e = {ex, ev, edn, er, eb}; v.det = det;
        vq.push_back(v);
    endtask

    task automatic idl(input string nm, input logic r, input logic l, input logic [7:0] d,
                       input int det = -1);
        add(nm, r, l, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, det);
    endtask

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {x,vld,done,rdy,busy}=%b expected %b", nm, act, exp);
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] s;
        logic [7:0]  lsb_bits;

        rst = 1'b1; load = 1'b0; din = 8'h00;
        rst1 = 1'b1; load1 = 1'b0; din1 = 8'h00;

        // reset with a concurrent offer: offer dropped
        idl("rst_prio", 1'b1, 1'b1, 8'hFF);
        idl("rst_idle", 1'b0, 1'b0, 8'h00);
        idl("rst_idle2", 1'b0, 1'b0, 8'h00);

        // single word 8'hB0
        w = 8'hB0;
        for (int i = 0; i < 8; i++)
            add("single", 1'b0, i == 0, w, w[7-i], 1'b1, i == 7, 1'b1, 1'b1);
        idl("single_end", 1'b0, 1'b0, 8'h00, 1);

        // back-to-back A5 then 5A, FF offers while holding buffer full
        s = 16'hA55A;
        for (int i = 0; i < 16; i++)
            add("b2b", 1'b0, (i == 0) || (i == 2) || (i == 4) || (i == 8),
                (i == 0) ? 8'hA5 : (i == 2) ? 8'h5A : 8'hFF,
                s[15-i], 1'b1, (i == 7) || (i == 15), !((i >= 2) && (i <= 7)), 1'b1);
        idl("b2b_end", 1'b0, 1'b0, 8'h00);
        idl("b2b_end2", 1'b0, 1'b0, 8'h00);

        // 0F offered exactly on the last bit of 81, holding buffer empty
        s = 16'h810F;
        for (int i = 0; i < 16; i++)
            add("lastbit", 1'b0, (i == 0) || (i == 8), (i == 0) ? 8'h81 : 8'h0F,
                s[15-i], 1'b1, (i == 7) || (i == 15), 1'b1, 1'b1);
        idl("lastbit_end", 1'b0, 1'b0, 8'h00);

        // reset during bit 3 of B0 with 5A held
        add("midrst", 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        add("midrst", 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add("midrst", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idl("midrst_rst", 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 10; i++) idl("midrst_after", 1'b0, 1'b0, 8'h00);

        @(posedge clk); #1;
        foreach (vq[k]) begin
            rst = vq[k].r; load = vq[k].l; din = vq[k].d;
            @(posedge clk); #1;
            if (x_valid) begin
                det_w = {det_w[2:0], x};
                if (det_w == 4'b1011) det_cnt++;
            end else begin
                det_w = 4'd0;
            end
            chk($sformatf("%s[%0d]", vq[k].nm, k), {x, x_valid, word_done, ready, busy}, vq[k].e);
            if (vq[k].det >= 0) chk_int("det1011", det_cnt, vq[k].det);
        end
        rst = 1'b0; load = 1'b0;

        // LSB-first, IDLE_BIT=1: 8'h0D -> 1,0,1,1,0,0,0,0
        @(posedge clk); #1;
        rst1 = 1'b0;
        @(posedge clk); #1;
        chk("lsb_reset", {x1, x_valid1, word_done1, ready1, busy1}, 5'b10010);
        load1 = 1'b1; din1 = 8'h0D;
        lsb_bits = 8'b1011_0000;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            load1 = 1'b0; din1 = 8'h00;
            chk($sformatf("lsb_bit%0d", i), {x1, x_valid1, word_done1, ready1, busy1},
                {lsb_bits[7-i], 1'b1, i == 7, 1'b1, 1'b1});
        end
        @(posedge clk); #1;
        chk("lsb_idle", {x1, x_valid1, word_done1, ready1, busy1}, 5'b10010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
